mandala_pattern_engine: RTL

MANDALA_PATTERN_ENGINE -- requirements
Module: mandala_pattern_engine

---
 rtl/mandala_pattern_engine_if.sv | 29 ++
 rtl/mandala_pattern_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mandala_pattern_engine_if.sv
// mandala_pattern_engine_if
// Video bus between a sync generator and the mandala pattern engine.
//   hpos, vpos            : current pixel coordinates (10 bits each)
//   display_on            : active-video flag aligned with hpos/vpos
//   hsync_in, vsync_in    : raw syncs (active-high pulses) aligned with hpos/vpos
//   hsync_out, vsync_out  : syncs delayed to match the pixel pipeline
//   rgb                   : {R[1:0],G[1:0],B[1:0]} pixel colour
// master : sync generator / display side (drives coordinates and syncs)
// slave  : the pattern engine (drives delayed syncs and colour)
interface mandala_pattern_engine_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic       hsync_out;
  logic       vsync_out;
  logic [5:0] rgb;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in,
    input  hsync_out, vsync_out, rgb
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in,
    output hsync_out, vsync_out, rgb
  );
endinterface

// File: rtl/mandala_pattern_engine.sv
// mandala_pattern_engine
// Draws an animated striped disc centred on (CENTER_X, CENTER_Y). A pixel is
// lit when it lies strictly inside the disc of squared radius R2_MAX and the
// angle-like value (dx XOR dy) + phase has bit SECTOR_BIT set. The phase is
// advanced once per frame while running, or single-stepped while paused.
//
// Ports:
//   clk    : pixel clock, the only clock
//   rst_n  : asynchronous active-low reset
//   vid    : video bus (slave modport) - coordinates/syncs in, delayed syncs
//            and rgb out, all outputs at 2-cycle latency
//   run    : 1 = animate every frame, 0 = paused
//   dir    : 0 = phase increments, 1 = phase decrements
//   speed  : phase step per frame while running (0 = hold)
//   step   : single-step request, rising-edge sensitive, only while paused
//   phase  : current animation phase
//
// Optional feature macro: MANDALA_COLOR_EN
//   defined   : on pixels show {r2[17:16], angle[top 2], phase[top 2]},
//               forced to 6'b000001 when that would be all zero
//   undefined : monochrome, on pixels 6'b111111
module mandala_pattern_engine #(
  parameter int CENTER_X   = 320,
  parameter int CENTER_Y   = 240,
  parameter int R2_MAX     = 40000,
  parameter int PHASE_W    = 8,
  parameter int SECTOR_BIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mandala_pattern_engine_if.slave vid,
  input  logic                    run,
  input  logic                    dir,
  input  logic [2:0]              speed,
  input  logic                    step,
  output logic [PHASE_W-1:0]      phase
);

  localparam logic [9:0]  CX     = 10'(CENTER_X);
  localparam logic [9:0]  CY     = 10'(CENTER_Y);
  localparam logic [20:0] R2_LIM = 21'(R2_MAX);

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } anim_state_t;

  anim_state_t state;

  // Stage 1 registers
  logic [9:0] dx_q;
  logic [9:0] dy_q;
  logic       de1_q;
  logic       hs1_q;
  logic       vs1_q;

  // Stage 2 registers
  logic [19:0] r2_q;
  logic        de2_q;
  logic        hs2_q;
  logic        vs2_q;

  // Edge-detect registers
  logic vs_prev_q;
  logic step_prev_q;

  logic [9:0]  dx_d;
  logic [9:0]  dy_d;
  logic [19:0] dx_sq;
  logic [19:0] dy_sq;
  logic [20:0] r2_sum;
  logic [19:0] r2_d;
  logic        frame_evt;
  logic        step_evt;
  logic        pixel_on;
  logic [PHASE_W-1:0] speed_ext;

  assign dx_d = (vid.hpos >= CX) ? (vid.hpos - CX) : (CX - vid.hpos);
  assign dy_d = (vid.vpos >= CY) ? (vid.vpos - CY) : (CY - vid.vpos);

  assign dx_sq  = {10'd0, dx_q} * {10'd0, dx_q};
  assign dy_sq  = {10'd0, dy_q} * {10'd0, dy_q};
  assign r2_sum = {1'b0, dx_sq} + {1'b0, dy_sq};
  // Far corners of a 1024x1024 space can exceed 20 bits; saturating keeps
  // such pixels outside any disc limit instead of wrapping back inside.
  assign r2_d   = r2_sum[20] ? 20'hFFFFF : r2_sum[19:0];

  assign speed_ext = {{(PHASE_W-3){1'b0}}, speed};

  // The edge registers clear to 0 and the FSM resets to PAUSE, where frame
  // events are ignored; by the first RUN cycle vs_prev_q already holds the
  // level seen at release, so a vsync already high then never counts.
  assign frame_evt = vid.vsync_in & ~vs_prev_q;
  assign step_evt  = step & ~step_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q  <= '0;
      dy_q  <= '0;
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      de1_q <= vid.display_on;
      hs1_q <= vid.hsync_in;
      vs1_q <= vid.vsync_in;
    end
  end

`ifdef MANDALA_COLOR_EN
  logic [PHASE_W-1:0] angle_q;
  logic [5:0]         color_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_q    <= '0;
      angle_q <= '0;
      de2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
    end else begin
      r2_q    <= r2_d;
      angle_q <= (dx_q[PHASE_W-1:0] ^ dy_q[PHASE_W-1:0]) + phase;
      de2_q   <= de1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  end

  assign pixel_on  = ({1'b0, r2_q} < R2_LIM) && angle_q[SECTOR_BIT];
  assign color_raw = {r2_q[17:16], angle_q[PHASE_W-1:PHASE_W-2],
                      phase[PHASE_W-1:PHASE_W-2]};
  // A lit pixel must never look black, so an all-zero colour is nudged.
  assign vid.rgb   = (de2_q && pixel_on) ?
                     ((color_raw == 6'd0) ? 6'b000001 : color_raw) : 6'b000000;
`else
  // Monochrome only needs the stripe bit of the angle, so only that bit is
  // kept in the stage-2 register.
  logic sector_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_q     <= '0;
      sector_q <= 1'b0;
      de2_q    <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
    end else begin
      r2_q     <= r2_d;
      sector_q <= 1'(((dx_q[PHASE_W-1:0] ^ dy_q[PHASE_W-1:0]) + phase)
                     >> SECTOR_BIT);
      de2_q    <= de1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
    end
  end

  assign pixel_on = ({1'b0, r2_q} < R2_LIM) && sector_q;
  assign vid.rgb  = (de2_q && pixel_on) ? 6'b111111 : 6'b000000;
`endif

  assign vid.hsync_out = hs2_q;
  assign vid.vsync_out = vs2_q;

  // Animation FSM. The step edge is only acted on in PAUSE and the frame
  // event only in RUN, so a coincident step and frame while paused applies
  // just the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PAUSE;
      phase       <= '0;
      vs_prev_q   <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      vs_prev_q   <= vid.vsync_in;
      step_prev_q <= step;
      state       <= run ? ST_RUN : ST_PAUSE;
      case (state)
        ST_RUN: begin
          if (frame_evt) begin
            phase <= dir ? (phase - speed_ext) : (phase + speed_ext);
          end
        end
        default: begin
          if (step_evt) begin
            phase <= dir ? (phase - 1'b1) : (phase + 1'b1);
          end
        end
      endcase
    end
  end

endmodule
